serial_code_lock: RTL

Parametrised serial code-lock controller, the next-generation successor to the fixed 4-bit Moore unlock FSM. It accepts a code MSB-first, one bit per cycle qualified by `ser_val`, and compares it against a reprogrammable code register. It then reports pass/fail. It adds an open window with code reprogramming, an inter-bit timeout, a consecutive-failure counter and a timed lockout. It sits between the keypad/serial front end and the bolt actuator driver.

---
 rtl/serial_code_lock.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/serial_code_lock.sv
// Serial code-lock controller: MSB-first code entry, pass/fail strobe, open window
// with code reprogramming, inter-bit timeout and timed lockout after repeated failures.
//   state     | meaning
//   S_IDLE    | waiting for first code bit
//   S_COLLECT | collecting remaining bits, idle timeout armed
//   S_PASS    | one-cycle success strobe, bolt released
//   S_FAIL    | one-cycle failure strobe
//   S_OPEN    | bolt held released, code register writable
//   S_LOCKOUT | input ignored until lockout timer expires
module serial_code_lock #(
  parameter int              CODE_W       = 4,
  parameter logic [CODE_W-1:0] CODE       = 'b1011,
  parameter bit              EARLY_REJECT = 1'b1,
  parameter int              TIMEOUT_CYC  = 32,
  parameter int              MAX_FAIL     = 3,
  parameter int              LOCKOUT_CYC  = 16,
  parameter int              OPEN_CYC     = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            ser_val,
  input  logic                            ser_data,
  input  logic                            prog_val,
  input  logic [CODE_W-1:0]               prog_code,
  output logic                            output_val,
  output logic                            unlock,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CNT_W   = $clog2(CODE_W + 1);
  localparam int IDX_W   = $clog2(CODE_W);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int IDLE_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_PASS, S_FAIL, S_OPEN, S_LOCKOUT
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                mismatch_q, mismatch_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [IDX_W-1:0]    bit_idx;
  logic                bit_wrong;
  logic                go_pass;
  logic                go_fail;

  assign bit_idx = IDX_W'(CODE_W - 1) - IDX_W'(bit_cnt_q);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    bit_cnt_d  = bit_cnt_q;
    mismatch_d = mismatch_q;
    fail_cnt_d = fail_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tmr_d      = tmr_q;
    bit_wrong  = 1'b0;
    go_pass    = 1'b0;
    go_fail    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ser_val) begin
          bit_wrong  = (ser_data != code_q[CODE_W-1]);
          bit_cnt_d  = CNT_W'(1);
          mismatch_d = bit_wrong;
          idle_cnt_d = '0;
          if (EARLY_REJECT && bit_wrong) go_fail = 1'b1;
          else                           state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // An accepted bit takes priority over a timeout on the same edge.
        if (ser_val) begin
          bit_wrong  = (ser_data != code_q[bit_idx]);
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          mismatch_d = mismatch_q | bit_wrong;
          idle_cnt_d = '0;
          if (EARLY_REJECT && bit_wrong) begin
            go_fail = 1'b1;
          end else if (bit_cnt_q == CNT_W'(CODE_W - 1)) begin
            if (mismatch_q || bit_wrong) go_fail = 1'b1;
            else                         go_pass = 1'b1;
          end
        end else if (TIMEOUT_CYC != 0) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) go_fail = 1'b1;
        end
      end
      S_PASS: begin
        state_d = S_OPEN;
        tmr_d   = TMR_W'(OPEN_CYC - 1);
      end
      S_OPEN: begin
        if (prog_val) code_d = prog_code;
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      S_FAIL: begin
        if (fail_cnt_q == FAIL_W'(MAX_FAIL)) begin
          state_d = S_LOCKOUT;
          tmr_d   = TMR_W'(LOCKOUT_CYC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d    = S_IDLE;
          fail_cnt_d = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_fail || go_pass) begin
      bit_cnt_d  = '0;
      mismatch_d = 1'b0;
      idle_cnt_d = '0;
    end
    if (go_fail) begin
      state_d    = S_FAIL;
      fail_cnt_d = fail_cnt_q + FAIL_W'(1);
    end
    if (go_pass) begin
      state_d    = S_PASS;
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      code_q     <= CODE;
      bit_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      fail_cnt_q <= '0;
      idle_cnt_q <= '0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      bit_cnt_q  <= bit_cnt_d;
      mismatch_q <= mismatch_d;
      fail_cnt_q <= fail_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tmr_q      <= tmr_d;
    end
  end

  assign output_val = (state_q == S_PASS) || (state_q == S_FAIL);
  assign unlock     = (state_q == S_PASS) || (state_q == S_OPEN);
  assign locked_out = (state_q == S_LOCKOUT);
  assign fail_cnt   = fail_cnt_q;

endmodule
